// File: rtl/load_unit.sv
// Load unit: decodes RISC-V load width, issues one or two aligned memory reads
// (two when the access crosses a word boundary), then aligns and extends the result.
module load_unit #(
  parameter int XLEN          = 32,
  parameter int ADDR_W        = 32,
  parameter int MISALIGNED_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the sender holds valid and its payload stable until that edge.

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   beat0_q, beat1_q;
  logic              req_ready_q, mem_req_valid_q, rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0] mem_addr_q;

  function automatic logic [3:0] size_of(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  function automatic logic crosses(input logic [OFF_W-1:0] off, input logic [2:0] f3);
    return (int'(off) + int'(size_of(f3))) > BYTES;
  endfunction

  function automatic logic illegal(input logic [2:0] f3);
    return (f3 == 3'b111) || ((XLEN != 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
  endfunction

  logic              req_err;
  logic [ADDR_W-1:0] req_aligned, line0_q, line1_q;
  logic              cross_q;
  logic [OFF_W-1:0]  off_q;

  assign req_err     = illegal(req_funct3) ||
                       ((MISALIGNED_EN == 0) && crosses(req_addr[OFF_W-1:0], req_funct3));
  assign req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign off_q       = addr_q[OFF_W-1:0];
  assign cross_q     = crosses(off_q, funct3_q);
  assign line0_q     = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign line1_q     = line0_q + ADDR_W'(BYTES);

  // Shift the wanted bytes to the top, then shift back arithmetically or logically.
  logic [XLEN-1:0] raw, shl, fmt;
  logic [6:0]      shamt;
  always_comb begin
    raw   = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});
    shamt = 7'(XLEN) - {size_of(funct3_q), 3'b000};
    shl   = raw << shamt;
    if (funct3_q[2] || (funct3_q[1:0] == 2'b11)) fmt = shl >> shamt;
    else                                          fmt = $unsigned($signed(shl) >>> shamt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      funct3_q        <= '0;
      beat0_q         <= '0;
      beat1_q         <= '0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            funct3_q    <= req_funct3;
            beat0_q     <= '0;
            beat1_q     <= '0;
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q         <= ISSUE0;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= req_aligned;
            end
          end
        end
        ISSUE0: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= WAIT0;
        end
        WAIT0: if (mem_rvalid) begin
          beat0_q <= mem_rdata;
          if (cross_q) begin
            state_q         <= ISSUE1;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= line1_q;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end
        end
        ISSUE1: if (mem_req_ready) begin
          mem_req_valid_q <= 1'b0;
          state_q         <= WAIT1;
        end
        WAIT1: if (mem_rvalid) begin
          beat1_q     <= mem_rdata;
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  // Data is a pure function of held registers, so it is stable for the whole RESP.
  assign rsp_data      = (rsp_valid_q && !rsp_err_q) ? fmt : '0;
  assign dbg_state     = state_q;

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have parameter MISALIGNED_EN, default 1; 1 = split boundary-crossing loads, 0 = flag them as errors.
REQ-004 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_addr input ADDR_W, req_funct3 input 3: load request from pipeline.
REQ-007 SHALL have ports mem_req_valid output 1, mem_req_ready input 1, mem_addr output ADDR_W: memory read command.
REQ-008 SHALL have ports mem_rvalid input 1, mem_rdata input XLEN: memory read return, at most one outstanding.
REQ-009 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output XLEN, rsp_err output 1: result to writeback.

Function
REQ-010 SHALL decode req_funct3 as: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- 011 and 110 are legal only when XLEN=64; 111 is always illegal.
REQ-011 SHALL implement FSM states IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
REQ-012 SHALL assert req_ready only in IDLE, and SHALL accept a request on req_valid && req_ready, registering address and funct3.
REQ-013 SHALL set byte offset = addr[log2(XLEN/8)-1:0] and size = 1/2/4/8 bytes from funct3.
- An access crosses when offset + size > XLEN/8.
REQ-014 SHALL handle an accepted illegal funct3, or a crossing access with MISALIGNED_EN=0, as follows:
- go directly to RESP with rsp_err=1 and rsp_data=0;
- issue no mem_req_valid.
REQ-015 SHALL otherwise go to ISSUE0 and drive mem_req_valid=1 with mem_addr = addr with low log2(XLEN/8) bits cleared.
- mem_addr SHALL hold stable until mem_req_ready.
REQ-016 SHALL leave ISSUE0 for WAIT0 on mem_req_ready, and SHALL capture mem_rdata as beat0 on mem_rvalid in WAIT0.
REQ-017 SHALL, after beat0, go to RESP for a non-crossing access, or to ISSUE1 for a crossing access.
- ISSUE1 uses mem_addr = aligned addr + XLEN/8, wrapping modulo 2^ADDR_W.
- ISSUE1 and WAIT1 mirror ISSUE0 and WAIT0, capturing beat1.
REQ-018 SHALL form raw = {beat1, beat0} >> (8*offset), with beat1 = 0 when not crossing.
- It SHALL take the low size bytes of raw.
- It SHALL sign-extend to XLEN for LB/LH/LW, and zero-extend for LBU/LHU/LWU.
- LD passes the value through unchanged.
REQ-019 SHALL hold rsp_valid=1, rsp_data and rsp_err stable in RESP until rsp_ready.
- On rsp_ready it SHALL return to IDLE, so req_ready is 1 in the following cycle.
REQ-020 SHALL ignore mem_rvalid outside WAIT0/WAIT1, and ignore req_valid outside IDLE.
REQ-021 SHALL, with mem_req_ready and mem_rvalid held high and rsp_ready held high, have the following latency from the request-accept edge to rsp_valid:
- 3 cycles for an aligned access (ISSUE0, WAIT0, RESP);
- 5 cycles for a crossing access.
REQ-022 SHALL keep mem_req_valid=0 in every state except ISSUE0/ISSUE1.

Reset
REQ-023 SHALL, on rst_n=0, immediately and asynchronously enter IDLE and clear all of the following:
- req_ready=0 while reset is asserted, then 1 in IDLE;
- mem_req_valid=0, mem_addr=0;
- rsp_valid=0, rsp_data=0, rsp_err=0;
- beat registers = 0.
REQ-024 SHALL, if reset is asserted mid-transaction, abandon the transaction.
- Any later mem_rvalid SHALL be ignored until a new request reaches WAIT0.

Verification
REQ-025 SHALL cover the following scenario: XLEN=32, LB at addr 0x1003, mem_rdata=0x80FF_1234 -> one memory access at 0x1000; rsp_data=0xFFFF_FF80; rsp_err=0.
REQ-026 SHALL cover the following scenario: XLEN=32, LHU at addr 0x2002, mem_rdata=0xBEEF_0000 -> rsp_data=0x0000_BEEF.
REQ-027 SHALL cover the following scenario: XLEN=32, MISALIGNED_EN=1, LW at addr 0x3003, beat0=0xAABB_CCDD, beat1=0x1122_3344 -> two accesses, at 0x3000 and 0x3004; rsp_data=0x223344AA; latency 5 cycles.
REQ-028 SHALL cover the following scenarios with no mem_req_valid and rsp_err=1, rsp_data=0:
- MISALIGNED_EN=0, LW at addr 0x3001;
- funct3=111;
- XLEN=32 with funct3=011.
REQ-029 SHALL cover the following scenario: XLEN=64, LWU at addr 0x10, mem_rdata=0x0000_0000_F000_0001 -> rsp_data=0x0000_0000_F000_0001; then LW at the same data -> rsp_data=0xFFFF_FFFF_F000_0001.
REQ-030 SHALL cover the following scenarios:
- backpressure and reset: mem_req_ready low 4 cycles with mem_addr held; then rsp_ready low 3 cycles with rsp_data held; then rst_n pulsed in WAIT0 -> IDLE and all outputs 0;
- a stray mem_rvalid after reset -> no rsp_valid.
